// File: rtl/io_bus_pkg.sv
// Shared IO_bus definitions: handshake state encoding, RW direction codes, default widths.
package io_bus_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/io_bus_addr_decoder.sv
// Base/range decode of an IO_bus register address into a local register index.
module io_bus_addr_decoder
  import io_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] reg_address,
  output logic                  selected_c,
  output logic [IDX_W-1:0]      index_c
);

  localparam int unsigned OFS_W = ADDR_WIDTH + 1;

  logic [OFS_W-1:0] offset;

  // One extra bit keeps addresses below the base from wrapping into range.
  always_comb begin
    offset     = {1'b0, reg_address} - OFS_W'(BASE_ADDR);
    selected_c = (offset < OFS_W'(NUM_REGS));
    index_c    = IDX_W'(offset);
  end

endmodule

// File: rtl/io_bus_reg_slave.sv
// IO_bus register slave: RW control bank, RO status bank, four-phase handshake, sticky fault.
module io_bus_reg_slave
  import io_bus_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned           BASE_ADDR   = 0,
  parameter int unsigned           NUM_RW      = 6,
  parameter int unsigned           NUM_RO      = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        data_out,
  input  logic [ADDR_WIDTH-1:0]        reg_address,
  input  logic                         RW,
  input  logic                         handshake_1,
  input  logic                         register_address_valid,
  output tri   [DATA_WIDTH-1:0]        data_in,
  output tri                           handshake_2,
  output tri                           nFault,
  output logic [NUM_RW*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_RO*DATA_WIDTH-1:0] status_in,
  output logic [NUM_RW-1:0]            wr_strobe,
  output logic [NUM_RW+NUM_RO-1:0]     rd_strobe,
  input  logic                         fault_clear
);

  localparam int unsigned NUM_REGS = NUM_RW + NUM_RO;
  localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // The decoded register window must fit inside the address space.
  if (64'(BASE_ADDR) + 64'(NUM_REGS) > (64'd1 << ADDR_WIDTH)) begin : g_bad_window
    $error("io_bus_reg_slave: register window exceeds address space");
  end

  state_e                         state_q, state_d;
  logic                           selected_c;
  logic [IDX_W-1:0]               index_c;
  logic                           accept_c;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           rw_q, rw_d;
  logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]          rd_data_q, rd_data_d;
  logic [NUM_RW*DATA_WIDTH-1:0]   reg_d;
  logic [NUM_RW-1:0]              wr_strobe_q, wr_strobe_d;
  logic [NUM_REGS-1:0]            rd_strobe_q, rd_strobe_d;
  logic                           fault_q, fault_d, fault_set_c;
  logic                           seen_low_q, seen_low_d;
  logic                           bus_drive_c, hs2_level_c;

  io_bus_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_addr_decoder (
    .reg_address (reg_address),
    .selected_c  (selected_c),
    .index_c     (index_c)
  );

  // A request is taken only once the master has been seen low since the last acknowledge.
  assign accept_c = (state_q == IDLE) && handshake_1 && register_address_valid
                    && selected_c && seen_low_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic for the four-phase handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = ACCESS;
      ACCESS:  state_d = ACK;
      ACK:     if (!handshake_1) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus drive enables: driven only through ACK and RELEASE.
  always_comb begin
    bus_drive_c = 1'b0;
    hs2_level_c = 1'b0;
    case (state_q)
      ACK:     begin bus_drive_c = 1'b1; hs2_level_c = 1'b1; end
      RELEASE: begin bus_drive_c = 1'b1; hs2_level_c = 1'b0; end
      default: begin bus_drive_c = 1'b0; hs2_level_c = 1'b0; end
    endcase
  end

  // Request capture, register access, strobes and fault flag.
  always_comb begin
    idx_d       = idx_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    reg_d       = reg_q;
    wr_strobe_d = '0;
    rd_strobe_d = '0;
    fault_set_c = 1'b0;
    seen_low_d  = seen_low_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          idx_d      = index_c;
          rw_d       = RW;
          wdata_d    = data_out;
          seen_low_d = 1'b0;
        end else if (!handshake_1) begin
          seen_low_d = 1'b1;
        end
      end
      ACCESS: begin
        rd_data_d = '0;
        if (rw_q == RW_WRITE) begin
          // A write that matches no RW register targets a status register.
          fault_set_c = 1'b1;
          for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (idx_q == IDX_W'(i)) begin
              reg_d[i*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
              wr_strobe_d[i]                    = 1'b1;
              fault_set_c                       = 1'b0;
            end
          end
        end else begin
          for (int unsigned i = 0; i < NUM_RW; i++) begin
            if (idx_q == IDX_W'(i)) rd_data_d = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
          end
          for (int unsigned i = 0; i < NUM_RO; i++) begin
            if (idx_q == IDX_W'(NUM_RW + i)) rd_data_d = status_in[i*DATA_WIDTH +: DATA_WIDTH];
          end
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            rd_strobe_d[i] = (idx_q == IDX_W'(i));
          end
        end
      end
      RELEASE: begin
        if (!handshake_1) seen_low_d = 1'b1;
      end
      default: begin
      end
    endcase
    // Sticky flag; a new set outranks a simultaneous clear.
    fault_d = fault_set_c | (fault_q & ~fault_clear);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q       <= '0;
      rw_q        <= RW_READ;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      reg_q       <= {NUM_RW{RESET_VALUE}};
      wr_strobe_q <= '0;
      rd_strobe_q <= '0;
      fault_q     <= 1'b0;
      seen_low_q  <= 1'b1;
    end else begin
      idx_q       <= idx_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      reg_q       <= reg_d;
      wr_strobe_q <= wr_strobe_d;
      rd_strobe_q <= rd_strobe_d;
      fault_q     <= fault_d;
      seen_low_q  <= seen_low_d;
    end
  end

  assign data_in     = bus_drive_c ? rd_data_q : {DATA_WIDTH{1'bz}};
  assign handshake_2 = bus_drive_c ? hs2_level_c : 1'bz;
  assign nFault      = fault_q ? 1'b0 : 1'bz;
  assign wr_strobe   = wr_strobe_q;
  assign rd_strobe   = rd_strobe_q;

endmodule

// File: tb/tb_io_bus_reg_slave.sv
// Bench for io_bus_reg_slave: two identical DUTs, one on pulled-up and one on pulled-down
// bus nets, so a released wire is distinguishable from a driven 0 or 1.
module tb_io_bus_reg_slave;

  localparam int unsigned BASE = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  data_out = '0;
  logic [7:0]   reg_address = '0;
  logic         rw = 1'b0;
  logic         h1 = 1'b0;
  logic         valid = 1'b0;
  logic         fault_clear = 1'b0;
  logic [63:0]  status_in = {32'h0, 32'h55};

  tri   [31:0]  din_pu, din_pd;
  tri           hs2_pu, hs2_pd, nf_pu, nf_pd;
  logic [191:0] regq_pu, regq_pd;
  logic [5:0]   wr_pu, wr_pd;
  logic [7:0]   rd_pu, rd_pd;

  pullup   (hs2_pu);
  pulldown (hs2_pd);
  pullup   (nf_pu);
  pulldown (nf_pd);
  for (genvar g = 0; g < 32; g++) begin : g_pull
    pullup   (din_pu[g]);
    pulldown (din_pd[g]);
  end

  always #5 clk = ~clk;

  io_bus_reg_slave #(.BASE_ADDR(BASE)) u_pu (
    .clk(clk), .reset(reset), .data_out(data_out), .reg_address(reg_address), .RW(rw),
    .handshake_1(h1), .register_address_valid(valid), .data_in(din_pu), .handshake_2(hs2_pu),
    .nFault(nf_pu), .reg_q(regq_pu), .status_in(status_in), .wr_strobe(wr_pu),
    .rd_strobe(rd_pu), .fault_clear(fault_clear)
  );

  io_bus_reg_slave #(.BASE_ADDR(BASE)) u_pd (
    .clk(clk), .reset(reset), .data_out(data_out), .reg_address(reg_address), .RW(rw),
    .handshake_1(h1), .register_address_valid(valid), .data_in(din_pd), .handshake_2(hs2_pd),
    .nFault(nf_pd), .reg_q(regq_pd), .status_in(status_in), .wr_strobe(wr_pd),
    .rd_strobe(rd_pd), .fault_clear(fault_clear)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Transaction-timeline model: a request accepted at edge `acc` takes effect at acc+1,
  // is acknowledged from cycle acc+1, released the cycle after the master is seen low.
  int          cyc = 0;
  int          acc = 0;
  int          low = -1;
  bit          m_busy = 0;
  bit          m_ready = 1;
  bit          m_fault = 0;
  logic        m_rw = 1'b0;
  logic [2:0]  m_idx = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_regs [6];
  logic [5:0]  e_wr = '0;
  logic [7:0]  e_rd = '0;
  int          wr_hits [6];
  int          rd_hits [8];

  initial begin
    for (int i = 0; i < 6; i++) begin m_regs[i] = '0; wr_hits[i] = 0; end
    for (int i = 0; i < 8; i++) rd_hits[i] = 0;
  end

  task automatic model_step();
    bit f_next;
    int d;
    cyc++;
    e_wr = '0;
    e_rd = '0;
    if (reset) begin
      m_busy = 0; m_ready = 1; m_fault = 0; low = -1; m_rdata = '0;
      for (int i = 0; i < 6; i++) m_regs[i] = '0;
    end else begin
      f_next = m_fault && !fault_clear;
      d = int'(reg_address) - int'(BASE);
      if (m_busy) begin
        if (low >= 0 && cyc == low + 1) begin
          m_busy  = 0;
          m_ready = !h1;
        end else if (cyc == acc + 1) begin
          if (m_rw == 1'b0) begin
            m_rdata = '0;
            if (m_idx < 3'd6) begin m_regs[m_idx] = m_wdata; e_wr[m_idx] = 1'b1; end
            else f_next = 1;
          end else begin
            if (m_idx < 3'd6)       m_rdata = m_regs[m_idx];
            else if (m_idx == 3'd6) m_rdata = status_in[31:0];
            else                    m_rdata = status_in[63:32];
            e_rd[m_idx] = 1'b1;
          end
        end else if (low < 0 && cyc >= acc + 2 && !h1) begin
          low = cyc;
        end
      end else if (h1 && valid && d >= 0 && d < 8 && m_ready) begin
        m_busy = 1; acc = cyc; low = -1; m_ready = 0;
        m_idx = 3'(d); m_rw = rw; m_wdata = data_out;
      end else if (!h1) begin
        m_ready = 1;
      end
      m_fault = f_next;
    end
  endtask

  task automatic compare();
    bit           drv;
    logic [191:0] flat;
    drv = m_busy && (cyc >= acc + 1);
    if (drv) begin
      chk("hs2_level", 192'({hs2_pu, hs2_pd}), 192'((low < 0) ? 2'b11 : 2'b00));
      chk("din_pu", 192'(din_pu), 192'(m_rdata));
      chk("din_pd", 192'(din_pd), 192'(m_rdata));
    end else begin
      chk("hs2_float", 192'({hs2_pu, hs2_pd}), 192'(2'b10));
      chk("din_float_pu", 192'(din_pu), 192'(32'hFFFF_FFFF));
      chk("din_float_pd", 192'(din_pd), 192'(32'h0));
    end
    chk("nfault", 192'({nf_pu, nf_pd}), 192'(m_fault ? 2'b00 : 2'b10));
    for (int i = 0; i < 6; i++) flat[i*32 +: 32] = m_regs[i];
    chk("reg_q", regq_pu, flat);
    chk("wr_strobe", 192'(wr_pu), 192'(e_wr));
    chk("rd_strobe", 192'(rd_pu), 192'(e_rd));
    for (int i = 0; i < 6; i++) wr_hits[i] += int'(wr_pu[i]);
    for (int i = 0; i < 8; i++) rd_hits[i] += int'(rd_pu[i]);
  endtask

  // Every-cycle compare against the model.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      compare();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Full master transaction; clr pulses fault_clear into the access edge.
  task automatic do_txn(input logic [7:0] addr, input logic dir, input logic [31:0] wdata,
                        input int hold, input bit clr, output logic [31:0] rdata, output int lat);
    bit got;
    @(negedge clk);
    reg_address = addr; rw = dir; data_out = wdata; valid = 1'b1; h1 = 1'b1;
    lat = 0; got = 0; rdata = '0;
    while (!got && lat < 10) begin
      @(posedge clk); #1; lat++;
      if (hs2_pu == 1'b1 && hs2_pd == 1'b1) begin got = 1; rdata = din_pd; end
      else if (clr && lat == 1) begin @(negedge clk); fault_clear = 1'b1; end
    end
    fault_clear = 1'b0;
    chk("ack_seen", 192'(got), 192'(1'b1));
    repeat (hold) begin
      @(negedge clk);
      reg_address = 8'($urandom); data_out = $urandom; rw = 1'($urandom);
      status_in = {$urandom, $urandom};
      chk("hold_hs2", 192'(hs2_pd), 192'(1'b1));
    end
    @(negedge clk);
    h1 = 1'b0; valid = 1'($urandom); reg_address = 8'($urandom);
    @(posedge clk); #1;
    chk("rel_hs2_low", 192'({hs2_pu, hs2_pd}), 192'(2'b00));
    @(posedge clk); #1;
    chk("rel_hs2_float", 192'({hs2_pu, hs2_pd}), 192'(2'b10));
  endtask

  // Request to an address owned by another slave: nothing may answer.
  task automatic do_miss(input logic [7:0] addr, input int cycles);
    @(negedge clk);
    reg_address = addr; rw = 1'($urandom); data_out = $urandom; valid = 1'b1; h1 = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
      chk("miss_hs2", 192'({hs2_pu, hs2_pd}), 192'(2'b10));
      chk("miss_din", 192'({din_pu, din_pd}), 192'({32'hFFFF_FFFF, 32'h0}));
    end
    @(negedge clk);
    h1 = 1'b0; valid = 1'b0;
  endtask

  function automatic int strobe_total();
    int s = 0;
    for (int i = 0; i < 6; i++) s += wr_hits[i];
    for (int i = 0; i < 8; i++) s += rd_hits[i];
    return s;
  endfunction

  initial begin
    logic [31:0] d;
    int          lat;
    int          base_cnt;
    logic [7:0]  a;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_regq", regq_pu, 192'(0));
    chk("rst_hs2", 192'({hs2_pu, hs2_pd}), 192'(2'b10));
    chk("rst_nfault", 192'({nf_pu, nf_pd}), 192'(2'b10));

    base_cnt = wr_hits[2];
    do_txn(8'h12, 1'b0, 32'hDEAD_BEEF, 0, 0, d, lat);
    chk("wr_latency", 192'(lat), 192'(2));
    chk("wr_reg2", 192'(regq_pu[95:64]), 192'(32'hDEAD_BEEF));
    chk("wr_one_pulse", 192'(wr_hits[2] - base_cnt), 192'(1));

    base_cnt = rd_hits[2];
    do_txn(8'h12, 1'b1, 32'h0, 0, 0, d, lat);
    chk("rd_reg2", 192'(d), 192'(32'hDEAD_BEEF));
    chk("rd_one_pulse", 192'(rd_hits[2] - base_cnt), 192'(1));

    do_txn(8'h16, 1'b1, 32'h0, 0, 0, d, lat);
    chk("rd_status0", 192'(d), 192'(32'h55));

    base_cnt = strobe_total();
    do_miss(8'h0F, 20);
    do_miss(8'h18, 20);
    chk("miss_no_strobe", 192'(strobe_total() - base_cnt), 192'(0));
    chk("miss_no_fault", 192'({nf_pu, nf_pd}), 192'(2'b10));

    do_txn(8'h17, 1'b0, 32'h1234, 0, 0, d, lat);
    chk("ro_wr_fault", 192'({nf_pu, nf_pd}), 192'(2'b00));
    repeat (5) @(negedge clk);
    chk("fault_sticky", 192'({nf_pu, nf_pd}), 192'(2'b00));
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    chk("fault_cleared", 192'({nf_pu, nf_pd}), 192'(2'b10));
    do_txn(8'h17, 1'b0, 32'h5678, 0, 1, d, lat);
    chk("set_beats_clear", 192'({nf_pu, nf_pd}), 192'(2'b00));
    @(negedge clk); fault_clear = 1'b1;
    @(negedge clk); fault_clear = 1'b0;

    base_cnt = wr_hits[3];
    do_txn(8'h13, 1'b0, 32'hA5A5_0003, 10, 0, d, lat);
    chk("held_one_pulse", 192'(wr_hits[3] - base_cnt), 192'(1));
    chk("held_reg3", 192'(regq_pu[127:96]), 192'(32'hA5A5_0003));

    @(negedge clk);
    reg_address = 8'h11; rw = 1'b0; data_out = 32'h1234_5678; valid = 1'b1; h1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_ack", 192'({hs2_pu, hs2_pd}), 192'(2'b11));
    chk("pre_rst_reg1", 192'(regq_pu[63:32]), 192'(32'h1234_5678));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_hs2", 192'({hs2_pu, hs2_pd}), 192'(2'b10));
    chk("rst_mid_regq", regq_pu, 192'(0));
    chk("rst_mid_wr", 192'(wr_pu), 192'(0));
    @(negedge clk);
    reset = 1'b0; h1 = 1'b0; valid = 1'b0;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      fault_clear = ($urandom_range(0, 5) == 0);
      status_in = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) begin
        a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(24, 255));
        do_miss(a, 4);
        fault_clear = 1'b0;
      end else begin
        a = 8'(BASE + $urandom_range(0, 7));
        do_txn(a, 1'($urandom), $urandom, $urandom_range(0, 3), 0, d, lat);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
